// File: rtl/wb_trace_recorder.sv
// Writeback trace recorder: captures register-file commits into a FWFT FIFO
// until the finish PC retires, then drains and raises done.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   debug_wb_pc/rf_wen/
//   rf_addr/rf_wdata         retiring-instruction writeback observation
//   rec_valid/rec_ready/
//   rec_data                 head-of-FIFO record, valid/ready handshake
//   rec_count                records accepted since reset (wraps)
//   overflow                 sticky, a record was dropped on a full FIFO
//   done                     capture ended and the FIFO has drained
`timescale 1ns/1ps
module wb_trace_recorder #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] FINISH_PC = 32'h00000070
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] debug_wb_pc,
  input  logic        debug_wb_rf_wen,
  input  logic [4:0]  debug_wb_rf_addr,
  input  logic [31:0] debug_wb_rf_wdata,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [71:0] rec_data,
  output logic [31:0] rec_count,
  output logic        overflow,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [71:0] r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic [AW:0] w_level;
  logic        w_empty;
  logic        w_full;
  logic        w_finish;
  logic        w_commit;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_last_pop;
  logic [71:0] w_rec;

  // Extra pointer bit makes the difference an exact occupancy 0..DEPTH.
  assign w_level  = r_wptr - r_rptr;
  assign w_empty  = (w_level == '0);
  assign w_full   = (w_level == (AW+1)'(DEPTH));
  assign w_finish = (debug_wb_pc == FINISH_PC);

  assign w_commit = (r_state == S_CAPTURE) && !w_finish &&
                    debug_wb_rf_wen && (debug_wb_rf_addr != 5'd0);

  assign w_pop  = !w_empty && rec_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts.
  assign w_push = w_commit && (!w_full || w_pop);
  assign w_drop = w_commit && w_full && !w_pop;

  assign w_last_pop = (w_level == (AW+1)'(1)) && w_pop;

  // The retiring PC is one instruction past the traced one.
  assign w_rec = {debug_wb_pc - 32'd4, 3'b000,
                  debug_wb_rf_addr, debug_wb_rf_wdata};

  assign rec_valid = !w_empty;
  assign rec_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CAPTURE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      rec_count <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr    <= r_wptr + (AW+1)'(1);
        rec_count <= rec_count + 32'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
      if (w_drop) begin
        overflow <= 1'b1;
      end
      unique case (r_state)
        S_CAPTURE: begin
          if (w_finish) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty || w_last_pop) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          done <= 1'b1;
        end
        default: begin
          r_state <= S_CAPTURE;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_recorder.sv
// Bench for wb_trace_recorder: vector table plus scripted corner sequences,
// with a queue scoreboard checking every popped record.
`timescale 1ns/1ps
module tb_wb_trace_recorder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] FIN   = 32'h00000070;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_addr;
  logic [31:0] debug_wb_rf_wdata;
  logic        rec_valid;
  logic        rec_ready;
  logic [71:0] rec_data;
  logic [31:0] rec_count;
  logic        overflow;
  logic        done;

  always #5 clk = ~clk;

  wb_trace_recorder #(
    .DEPTH(DEPTH),
    .FINISH_PC(FIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_addr(debug_wb_rf_addr),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_data(rec_data),
    .rec_count(rec_count),
    .overflow(overflow),
    .done(done)
  );

  int checks = 0;
  int errors = 0;

  logic [71:0] q[$];
  logic [31:0] m_count;
  bit          m_ovf;
  int          m_state;

  typedef struct {
    bit          w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
    bit          r;
    bit          ev;
    logic [31:0] ec;
    logic [71:0] ed;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input bit r);
    reset             = 1'b1;
    debug_wb_rf_wen   = 1'b0;
    debug_wb_rf_addr  = 5'd0;
    debug_wb_rf_wdata = 32'd0;
    debug_wb_pc       = 32'd0;
    rec_ready         = r;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_count = 32'd0;
    m_ovf   = 1'b0;
    m_state = 0;
    chk("rst_valid", 72'(rec_valid), 72'(0));
    chk("rst_count", 72'(rec_count), 72'(0));
    chk("rst_ovf", 72'(overflow), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
  endtask

  task automatic cycle(input bit w, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] p,
                       input bit r);
    logic [71:0] e;
    bit          commit;
    debug_wb_rf_wen   = w;
    debug_wb_rf_addr  = a;
    debug_wb_rf_wdata = d;
    debug_wb_pc       = p;
    rec_ready         = r;
    if (rec_valid && r) begin
      if (q.size() == 0) begin
        chk("pop_unexpected", 72'(1), 72'(0));
      end else begin
        e = q.pop_front();
        chk("pop_data", rec_data, e);
      end
    end
    commit = (m_state == 0) && (p != FIN) && w && (a != 5'd0);
    if (commit) begin
      if (q.size() < DEPTH) begin
        q.push_back({p - 32'd4, 3'b000, a, d});
        m_count = m_count + 32'd1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (m_state == 0 && p == FIN) m_state = 1;
    else if (m_state == 1 && q.size() == 0) m_state = 2;
    @(posedge clk);
    #1;
    chk("valid", 72'(rec_valid), 72'(q.size() != 0));
    chk("count", 72'(rec_count), 72'(m_count));
    chk("ovf", 72'(overflow), 72'(m_ovf));
    chk("done", 72'(done), 72'(m_state == 2));
  endtask

  initial begin
    tbl[0] = '{1, 5'd0, 32'hdeadbeef, 32'h10, 1, 0, 32'd0, 72'h0};
    tbl[1] = '{1, 5'd5, 32'h12345678, 32'h8, 1, 1, 32'd1,
               72'h00000004_05_12345678};
    tbl[2] = '{0, 5'd0, 32'h0, 32'h0, 1, 0, 32'd1, 72'h0};
    tbl[3] = '{1, 5'd31, 32'hffffffff, 32'h0, 0, 1, 32'd2,
               72'hfffffffc_1f_ffffffff};
    tbl[4] = '{1, 5'd1, 32'h0, 32'h4, 0, 1, 32'd3,
               72'hfffffffc_1f_ffffffff};
    tbl[5] = '{0, 5'd0, 32'h0, 32'h0, 1, 1, 32'd3,
               72'h00000000_01_00000000};
    tbl[6] = '{0, 5'd0, 32'h0, 32'h0, 1, 0, 32'd3, 72'h0};

    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].p, tbl[i].r);
      chk("tbl_valid", 72'(rec_valid), 72'(tbl[i].ev));
      chk("tbl_count", 72'(rec_count), 72'(tbl[i].ec));
      if (tbl[i].ev) chk("tbl_data", rec_data, tbl[i].ed);
    end

    // 17 events into a 16-deep FIFO, then drain in order.
    do_reset(1'b0);
    for (int i = 0; i < 17; i++)
      cycle(1, 5'((i % 31) + 1), $urandom, 32'h100 + 32'(4 * i), 0);
    chk("ovf_count", 72'(rec_count), 72'(16));
    chk("ovf_flag", 72'(overflow), 72'(1));
    for (int i = 0; i < 16; i++) cycle(0, 5'd0, 32'd0, 32'h0, 1);
    chk("ovf_drained", 72'(rec_valid), 72'(0));

    // Full FIFO with push and pop together.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++)
      cycle(1, 5'd3, $urandom, 32'h200 + 32'(4 * i), 0);
    chk("full_ovf0", 72'(overflow), 72'(0));
    cycle(1, 5'd9, 32'hcafef00d, 32'h300, 1);
    chk("pp_count", 72'(rec_count), 72'(17));
    chk("pp_ovf", 72'(overflow), 72'(0));
    for (int i = 0; i < 15; i++) cycle(0, 5'd0, 32'd0, 32'h0, 1);
    chk("pp_left1", 72'(rec_valid), 72'(1));
    cycle(0, 5'd0, 32'd0, 32'h0, 1);
    chk("pp_empty", 72'(rec_valid), 72'(0));

    // Finish with 3 buffered records.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1, 5'(i + 10), $urandom, 32'h400 + 32'(4 * i), 0);
    cycle(1, 5'd7, 32'h77777777, FIN, 0);
    chk("fin_count", 72'(rec_count), 72'(3));
    chk("fin_done0", 72'(done), 72'(0));
    for (int k = 0; k < 3; k++) begin
      cycle(1, 5'd3, 32'(k), 32'h500, 1);
      chk("fin_done", 72'(done), 72'(k == 2));
    end
    cycle(1, 5'd4, 32'h1, 32'h504, 1);
    cycle(1, 5'd4, 32'h2, FIN, 1);
    chk("fin_ignored", 72'(rec_count), 72'(3));
    chk("fin_hold", 72'(done), 72'(1));

    // Finish with an empty FIFO.
    do_reset(1'b0);
    cycle(0, 5'd0, 32'd0, FIN, 0);
    chk("fe_drain", 72'(done), 72'(0));
    cycle(0, 5'd0, 32'd0, 32'h0, 0);
    chk("fe_done", 72'(done), 72'(1));

    // Reset mid-operation with 5 buffered and the consumer ready.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1, 5'd6, $urandom, 32'h600 + 32'(4 * i), 0);
    chk("mid_count5", 72'(rec_count), 72'(5));
    do_reset(1'b1);
    cycle(1, 5'd2, 32'h00000abc, 32'h20, 0);
    chk("mid_capture", 72'(rec_count), 72'(1));
    chk("mid_data", rec_data, 72'h0000001c_02_00000abc);
    cycle(0, 5'd0, 32'd0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trace_recorder.md
WB_TRACE_RECORDER -- requirements
Module: wb_trace_recorder

Interface
REQ-001 Parameter DEPTH, default 16, sets the record FIFO depth in entries (power of two, >=2).
REQ-002 Parameter FINISH_PC, default 32'h00000070, is the writeback PC that ends capture.
REQ-003 Port clk, input, 1 bit, is the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port debug_wb_pc, input, 32 bits, is the PC of the instruction retiring in WB.
REQ-006 Port debug_wb_rf_wen, input, 1 bit, is the WB register-file write enable.
REQ-007 Port debug_wb_rf_addr, input, 5 bits, is the WB destination register.
REQ-008 Port debug_wb_rf_wdata, input, 32 bits, is the WB write data.
REQ-009 Port rec_valid, output, 1 bit, SHALL be high while rec_data holds an unread record.
REQ-010 Port rec_ready, input, 1 bit, is the consumer's acceptance of the record.
REQ-011 Port rec_data, output, 72 bits, is the head trace record.
REQ-012 Port rec_count, output, 32 bits, is the number of records accepted into the FIFO since reset.
REQ-013 Port overflow, output, 1 bit, is a sticky flag for a dropped record.
REQ-014 Port done, output, 1 bit, SHALL be high once capture has ended and the FIFO has drained.

Function
REQ-015 A commit event SHALL be debug_wb_rf_wen=1 and debug_wb_rf_addr!=0 in a cycle where state=CAPTURE and debug_wb_pc!=FINISH_PC.
REQ-016 Record format SHALL be: [71:40] = debug_wb_pc-4 (mod 2^32), [39:37] = 3'b000, [36:32] = addr, [31:0] = wdata.
REQ-017 The FSM SHALL have the states CAPTURE, DRAIN and DONE.
REQ-018 CAPTURE SHALL go to DRAIN on the first cycle with debug_wb_pc==FINISH_PC, regardless of wen; that cycle's write SHALL NOT be recorded.
REQ-019 DRAIN SHALL record no events and SHALL go to DONE on the cycle the FIFO becomes empty (or immediately if it is already empty).
REQ-020 DONE SHALL hold until reset; done=1 only in DONE.
REQ-021 The FIFO SHALL be first-word-fall-through; a record pushed in cycle N SHALL be visible with rec_valid=1 in cycle N+1 when the FIFO was empty.
REQ-022 A pop SHALL occur when rec_valid && rec_ready; rec_data and rec_valid SHALL stay stable while rec_valid && !rec_ready.
REQ-023 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full; occupancy is unchanged.
REQ-024 A push while full without a pop SHALL drop the record, set overflow, and leave rec_count unchanged.
REQ-025 rec_count SHALL increment by 1 for each accepted push and wrap modulo 2^32.
REQ-026 Read and write pointers SHALL wrap at DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter of width log2(DEPTH)+1.
REQ-027 Streaming SHALL be allowed in CAPTURE; a consumer may pop at any time.

Reset
REQ-028 With reset=1 at a rising edge: state<=CAPTURE, FIFO empty, rec_valid=0, rec_count=0, overflow=0, done=0.
REQ-029 rec_data SHALL be don't-care while rec_valid=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered records in the same edge, with no partial pop.

Verification
REQ-031 Reset, then wen=1, addr=5, wdata=32'h12345678, pc=32'h00000008, rec_ready=1 -> next cycle rec_valid=1, rec_data=72'h00000004_05_12345678, rec_count=1.
REQ-032 wen=1, addr=0, pc=32'h10 -> no record; rec_valid stays 0; rec_count=0.
REQ-033 rec_ready=0 and 17 events with DEPTH=16 -> 16 stored, overflow=1, rec_count=16; then 16 pops return records in capture order.
REQ-034 FIFO full, with a push and pop in the same cycle -> occupancy stays 16, overflow stays 0, rec_count increments.
REQ-035 3 records buffered, then pc=FINISH_PC with wen=1, addr=7 -> addr-7 write not recorded; done=0 until the 3rd pop, done=1 the following cycle; later events ignored.
REQ-036 reset=1 with 5 records buffered -> next cycle rec_valid=0, rec_count=0, overflow=0, state=CAPTURE.
